mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low (0 = reset, sampled at posedge clk).
REQ-005 SHALL have port start  input  1  E-stage instruction is an MDU op and E is not stalled.
REQ-006 SHALL have port md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 SHALL have port v_A_E  input  32  rs operand / dividend / MTHI-MTLO data.
REQ-008 SHALL have port v_B_E  input  32  rt operand / divisor.
REQ-009 SHALL have port d_md_use  input  1  D-stage instruction uses the MDU (mult/div/mthi/mtlo/mfhi/mflo).
REQ-010 SHALL have port rd_sel  input  1  0 selects LO, 1 selects HI for rd_data.
REQ-011 SHALL have port rd_data  output  32  combinational read of HI or LO register.
REQ-012 SHALL have port busy  output  1  arithmetic operation in flight.
REQ-013 SHALL have port stall_md  output  1  stall request to D-stage pipeline registers.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV; busy = (state != IDLE), registered-state derived.
REQ-015 In IDLE with start=1 and md_op MULT/MULTU SHALL latch the 64-bit product into pending registers, load counter with MULT_LAT, enter MUL.
REQ-016 In IDLE with start=1 and md_op DIV/DIVU SHALL latch quotient/remainder into pending registers, load counter with DIV_LAT, enter DIV.
REQ-017 In MUL/DIV, counter SHALL decrement each edge; at the edge where counter==1 SHALL write pending HI/LO and return to IDLE.
REQ-018 Latency: start sampled at edge 0 -> busy=1 for exactly LAT cycles after edge 0; HI/LO updated at edge LAT; busy=0 after edge LAT.
REQ-019 MULT SHALL be a signed 32x32->64 product, MULTU unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-020 DIV SHALL be signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI; DIVU unsigned.
REQ-021 Divisor zero SHALL still occupy DIV_LAT busy cycles and leave HI/LO unchanged at completion.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write v_A_E to HI/LO at that edge; state stays IDLE, busy stays 0.
REQ-023 start=1 while busy SHALL be ignored (no state, counter, HI/LO change); the hazard logic guarantees it does not occur.
REQ-024 md_op NONE/reserved with start=1 SHALL have no effect.
REQ-025 stall_md SHALL equal d_md_use & (busy | (start & md_op in MULT..DIVU)), combinational.
REQ-026 rd_data SHALL reflect HI/LO register contents only (no bypass of pending results).

Reset
REQ-027 reset=0 at a posedge SHALL force state IDLE, counter 0, HI=0, LO=0, pending registers 0, regardless of operation in progress.
REQ-028 After reset: busy=0, stall_md=d_md_use & start-arith term, rd_data=0.
REQ-029 reset SHALL take priority over start at the same edge.

Verification
REQ-030 MULT v_A_E=0xFFFFFFFF, v_B_E=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; HI/LO unchanged during busy.
REQ-032 DIV 0xFFFFFFF9 / 0x00000002 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 MTHI 0x12345678 in IDLE -> next cycle rd_sel=1 gives 0x12345678, busy=0; MTLO issued during MULT busy -> LO unaffected.
REQ-034 DIV started, reset=0 at 3rd busy cycle -> next cycle busy=0, rd_data=0 for both rd_sel, no later HI/LO write.
REQ-035 stall_md: d_md_use=1 with start MULT -> 1; d_md_use=1 with busy -> 1; d_md_use=0 with busy -> 0; d_md_use=1 with start MTHI in IDLE -> 0.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if -- pipeline <-> multiply/divide unit bus.
//   start     : E-stage instruction is an MDU op and E is not stalled
//   md_op     : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   v_A_E     : rs operand / dividend / MTHI-MTLO data
//   v_B_E     : rt operand / divisor
//   d_md_use  : D-stage instruction uses the MDU
//   rd_sel    : 0 reads LO, 1 reads HI
//   rd_data   : HI or LO register contents
//   busy      : arithmetic operation in flight
//   stall_md  : stall request to the D-stage pipeline registers
// The master modport is the pipeline side, the slave modport is the MDU.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] v_A_E;
  logic [31:0] v_B_E;
  logic        d_md_use;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall_md;

  modport master (
    output start, md_op, v_A_E, v_B_E, d_md_use, rd_sel,
    input  rd_data, busy, stall_md
  );

  modport slave (
    input  start, md_op, v_A_E, v_B_E, d_md_use, rd_sel,
    output rd_data, busy, stall_md
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide unit controller with HI/LO registers.
// The arithmetic result is computed when the op is accepted and parked in
// pending registers; a down-counter models the unit latency, and the
// pending value is committed to HI/LO on the last busy cycle.
// Ports:
//   clk   : single clock, all state changes on posedge
//   reset : synchronous, active-low
//   mdu   : mdu_ctrl_if slave modport (see mdu_ctrl_if.sv)
// Parameters:
//   MULT_LAT : busy cycles for MULT/MULTU (>= 1)
//   DIV_LAT  : busy cycles for DIV/DIVU   (>= 1)
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_ctrl_if.slave    mdu
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_skip_r;

  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] product_s;
  logic        div_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] b_safe_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        start_arith_s;

  // Product and quotient/remainder of the operands currently on the E-stage bus.
  always_comb begin
    // Sign-extend for MULT, zero-extend otherwise; the low 64 bits of the
    // product are then the correct two's-complement result in both cases.
    mul_a_s   = (mdu.md_op == OP_MULT) ? {{32{mdu.v_A_E[31]}}, mdu.v_A_E} : {32'd0, mdu.v_A_E};
    mul_b_s   = (mdu.md_op == OP_MULT) ? {{32{mdu.v_B_E[31]}}, mdu.v_B_E} : {32'd0, mdu.v_B_E};
    product_s = mul_a_s * mul_b_s;

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    div_signed_s = (mdu.md_op == OP_DIV);
    a_neg_s      = div_signed_s & mdu.v_A_E[31];
    b_neg_s      = div_signed_s & mdu.v_B_E[31];
    a_mag_s      = a_neg_s ? (32'd0 - mdu.v_A_E) : mdu.v_A_E;
    b_mag_s      = b_neg_s ? (32'd0 - mdu.v_B_E) : mdu.v_B_E;
    // A zero divisor never commits, so any non-zero stand-in keeps the divider defined.
    b_safe_s     = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s      = a_mag_s / b_safe_s;
    r_mag_s      = a_mag_s % b_safe_s;
    quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s        = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Arithmetic ops (MULT..DIVU) being presented this cycle.
  always_comb begin
    start_arith_s = mdu.start & (mdu.md_op >= OP_MULT) & (mdu.md_op <= OP_DIVU);
  end

  // Control FSM, latency counter, pending results and the HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      pend_hi_r   <= 32'd0;
      pend_lo_r   <= 32'd0;
      pend_skip_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mdu.start) begin
            case (mdu.md_op)
              OP_MULT, OP_MULTU: begin
                pend_hi_r   <= product_s[63:32];
                pend_lo_r   <= product_s[31:0];
                pend_skip_r <= 1'b0;
                cnt_r       <= CNT_W'(MULT_LAT);
                state_r     <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_r   <= rem_s;
                pend_lo_r   <= quot_s;
                pend_skip_r <= (mdu.v_B_E == 32'd0);
                cnt_r       <= CNT_W'(DIV_LAT);
                state_r     <= ST_DIV;
              end
              OP_MTHI: hi_r <= mdu.v_A_E;
              OP_MTLO: lo_r <= mdu.v_A_E;
              default: ;
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // start is ignored while busy; the hazard logic keeps it from arriving.
        ST_MUL, ST_DIV: begin
          if (cnt_r == CNT_W'(1)) begin
            if (!pend_skip_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign mdu.busy     = (state_r != ST_IDLE);
  assign mdu.stall_md = mdu.d_md_use & (mdu.busy | start_arith_s);
  assign mdu.rd_data  = mdu.rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with default latencies (MULT 5, DIV 10).
// Inputs change 1 time unit after posedge; outputs are sampled after settling.
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.rd_sel = 1'b1;
    #1;
    hi = bus.rd_data;
    bus.rd_sel = 1'b0;
    #1;
    lo = bus.rd_data;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.v_A_E = a;
    bus.v_B_E = b;
    step();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
  endtask

  // Issue an arithmetic op, count busy cycles, and verify HI/LO hold while busy.
  task automatic run_arith(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0, hi, lo;
    int          cyc;
    read_hilo(hi0, lo0);
    issue(op, a, b);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      read_hilo(hi, lo);
      vectors++;
      if (hi !== hi0 || lo !== lo0) begin
        errors++;
        $display("FAIL %s_hold cyc=%0d hi=%h lo=%h expected hi=%h lo=%h", name, cyc, hi, lo, hi0, lo0);
      end
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d expected %0d", name, cyc, exp_lat);
    end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_result hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b0;
    step();
    step();
    read_hilo(hi, lo);
    vectors++;
    if (bus.busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", bus.busy, hi, lo);
    end
    // During reset the stall still follows d_md_use & start-arith.
    bus.d_md_use = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'd1;
    #1;
    vectors++;
    if (bus.stall_md !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got %b expected 1", bus.stall_md);
    end
    // Reset wins over a start on the same edge.
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority busy=%b expected 0", bus.busy);
    end
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.d_md_use = 1'b0;
    reset        = 1'b1;
    step();
  endtask

  task automatic test_mult();
    run_arith("mult",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_arith("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_arith("mult_mixed", 3'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
  endtask

  task automatic test_div();
    run_arith("div_neg",  3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu_zero", 3'd4, 32'h0000_0007, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("div_negdivisor", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_arith("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_arith("divu", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'h0000_0001, 32'h7FFF_FFFC);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] hi, lo;
    int          cyc;
    issue(3'd5, 32'h1234_5678, 32'h0);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi hi=%h busy=%b expected hi=12345678 busy=0", hi, bus.busy);
    end
    issue(3'd6, 32'hCAFE_0001, 32'h0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hCAFE_0001 || hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo hi=%h lo=%h busy=%b expected hi=12345678 lo=cafe0001 busy=0", hi, lo, bus.busy);
    end
    // MTLO presented mid-MULT must be ignored; MULT 3*4 then commits.
    issue(3'd1, 32'h0000_0003, 32'h0000_0004);
    step();
    issue(3'd6, 32'hDEAD_BEEF, 32'h0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hCAFE_0001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_busy lo=%h busy=%b expected lo=cafe0001 busy=1", lo, bus.busy);
    end
    cyc = 2;
    while (bus.busy === 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    read_hilo(hi, lo);
    vectors++;
    if (cyc !== 5 || hi !== 32'h0 || lo !== 32'h0000_000C) begin
      errors++;
      $display("FAIL mtlo_busy_result lat=%0d hi=%h lo=%h expected lat=5 hi=0 lo=c", cyc, hi, lo);
    end
  endtask

  task automatic test_none();
    logic [31:0] hi, lo;
    issue(3'd0, 32'hAAAA_AAAA, 32'h1);
    issue(3'd7, 32'hBBBB_BBBB, 32'h1);
    read_hilo(hi, lo);
    vectors++;
    if (bus.busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000_000C) begin
      errors++;
      $display("FAIL none_op busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=c", bus.busy, hi, lo);
    end
  endtask

  task automatic test_stall();
    bus.d_md_use = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'd1;
    bus.v_A_E    = 32'd2;
    bus.v_B_E    = 32'd3;
    #1;
    vectors++;
    if (bus.stall_md !== 1'b1) begin
      errors++;
      $display("FAIL stall_start_mult got %b expected 1", bus.stall_md);
    end
    step();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    #1;
    vectors++;
    if (bus.stall_md !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy got %b expected 1", bus.stall_md);
    end
    bus.d_md_use = 1'b0;
    #1;
    vectors++;
    if (bus.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL stall_busy_nouse got %b expected 0", bus.stall_md);
    end
    repeat (6) step();
    bus.d_md_use = 1'b1;
    bus.start    = 1'b1;
    bus.md_op    = 3'd5;
    #1;
    vectors++;
    if (bus.stall_md !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_mthi got stall=%b busy=%b expected 0 0", bus.stall_md, bus.busy);
    end
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.d_md_use = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] hi, lo;
    issue(3'd5, 32'h5555_0000, 32'h0);
    issue(3'd3, 32'h0000_0064, 32'h0000_0007);
    step();
    step();
    // Third busy cycle: reset sampled at the next edge.
    reset = 1'b0;
    step();
    reset = 1'b1;
    read_hilo(hi, lo);
    vectors++;
    if (bus.busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_div busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", bus.busy, hi, lo);
    end
    repeat (12) step();
    read_hilo(hi, lo);
    vectors++;
    if (bus.busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_div_late busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", bus.busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    run_arith("b2b_multu", 3'd2, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);
    run_arith("b2b_div",   3'd3, 32'hFFFF_FF9C, 32'h0000_0007, 10, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.v_A_E    = 32'd0;
    bus.v_B_E    = 32'd0;
    bus.d_md_use = 1'b0;
    bus.rd_sel   = 1'b0;
    #1;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_none();
    test_stall();
    test_reset_mid_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
